// File: rtl/sr_ff_pkg.sv
// Shared definitions for the clocked SR storage bank: conflict-resolution
// mode codes and the per-bit next-state rule.
package sr_ff_pkg;

   localparam int MODE_SET_DOM = 0;
   localparam int MODE_RST_DOM = 1;
   localparam int MODE_HOLD    = 2;
   localparam int MODE_TOGGLE  = 3;

   // Next state of one enabled cell; S=R=1 is resolved by mode, never X.
   function automatic logic sr_next(input logic q, input logic s,
                                    input logic r, input logic [1:0] mode);
      logic nxt;
      nxt = q;
      case ({s, r})
         2'b10: nxt = 1'b1;
         2'b01: nxt = 1'b0;
         2'b11: begin
            case (mode)
               2'd0:    nxt = 1'b1;
               2'd1:    nxt = 1'b0;
               2'd2:    nxt = q;
               default: nxt = ~q;
            endcase
         end
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR channel: enable gating, q/qbar register, registered edge pulses
// and the sticky conflict flag. Exposes its raw conflict for the counter.
module sr_ff_cell
   import sr_ff_pkg::*;
#(
   parameter int   MODE = MODE_SET_DOM,
   parameter logic INIT = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic enb,
   input  logic ch_en,
   input  logic s,
   input  logic r,
   input  logic conflict_clr,
   output logic q,
   output logic qbar,
   output logic q_rise,
   output logic q_fall,
   output logic conflict,
   output logic cf
);

   logic act;
   logic q_next;

   always_comb begin
      act    = enb & ch_en;
      cf     = act & s & r;
      q_next = q;
      if (act) begin
         q_next = sr_next(q, s, r, 2'(MODE));
      end
   end

   // qbar lives in the same register stage as q so it is never a cycle off.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q        <= INIT;
         qbar     <= ~INIT;
         q_rise   <= 1'b0;
         q_fall   <= 1'b0;
         conflict <= 1'b0;
      end else begin
         q        <= q_next;
         qbar     <= ~q_next;
         q_rise   <= ~q & q_next;
         q_fall   <= q & ~q_next;
         // A conflict in the clearing cycle wins over the clear.
         conflict <= cf | (conflict & ~conflict_clr);
      end
   end

endmodule

// File: rtl/sr_ff_bank.sv
// WIDTH-channel clocked SR bank with shared enable, sticky conflict flags
// and a saturating count of cycles that contained any conflict.
module sr_ff_bank
   import sr_ff_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter int               MODE  = MODE_SET_DOM,
   parameter int               CNT_W = 8,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enb,
   input  logic [WIDTH-1:0] ch_en,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             conflict_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic [WIDTH-1:0] q_rise,
   output logic [WIDTH-1:0] q_fall,
   output logic [WIDTH-1:0] conflict,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cf;
   logic             any_cf;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      sr_ff_cell #(
         .MODE (MODE),
         .INIT (INIT[i])
      ) u_cell (
         .clk          (clk),
         .reset        (reset),
         .enb          (enb),
         .ch_en        (ch_en[i]),
         .s            (s[i]),
         .r            (r[i]),
         .conflict_clr (conflict_clr),
         .q            (q[i]),
         .qbar         (qbar[i]),
         .q_rise       (q_rise[i]),
         .q_fall       (q_fall[i]),
         .conflict     (conflict[i]),
         .cf           (cf[i])
      );
   end

   assign any_cf = |cf;

   // Clear loads 1 rather than 0 when a conflict lands in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflict_cnt <= '0;
      end else if (conflict_clr) begin
         conflict_cnt <= any_cf ? CNT_ONE : '0;
      end else if (any_cf && (conflict_cnt != CNT_MAX)) begin
         conflict_cnt <= conflict_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: one instance per conflict mode, each with a different
// counter width, all driven in parallel and checked against a vector model.
module tb_sr_ff_bank;

   localparam logic [7:0] INIT = 8'hA5;

   logic       clk = 1'b0;
   logic       reset;
   logic       enb;
   logic [7:0] ch_en;
   logic [7:0] s;
   logic [7:0] r;
   logic       conflict_clr;

   logic [7:0] q_o[4];
   logic [7:0] qbar_o[4];
   logic [7:0] rise_o[4];
   logic [7:0] fall_o[4];
   logic [7:0] conf_o[4];
   logic [7:0] cnt_o[4];

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   logic [7:0] m_q[4];
   logic [7:0] m_rise[4];
   logic [7:0] m_fall[4];
   logic [7:0] m_conf[4];
   int         m_cnt[4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int CW = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : 8;
      logic [CW-1:0] cnt_w;
      sr_ff_bank #(
         .WIDTH (8),
         .MODE  (g),
         .CNT_W (CW),
         .INIT  (INIT)
      ) u_dut (
         .clk          (clk),
         .reset        (reset),
         .enb          (enb),
         .ch_en        (ch_en),
         .s            (s),
         .r            (r),
         .conflict_clr (conflict_clr),
         .q            (q_o[g]),
         .qbar         (qbar_o[g]),
         .q_rise       (rise_o[g]),
         .q_fall       (fall_o[g]),
         .conflict     (conf_o[g]),
         .conflict_cnt (cnt_w)
      );
      assign cnt_o[g] = 8'(cnt_w);
   end

   function automatic int cnt_width(input int k);
      case (k)
         0:       return 2;
         1:       return 3;
         2:       return 4;
         default: return 8;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_q[k]    = INIT;
         m_rise[k] = 8'h00;
         m_fall[k] = 8'h00;
         m_conf[k] = 8'h00;
         m_cnt[k]  = 0;
      end
   endtask

   // Vector-wide application of the SR rules for one clock edge.
   task automatic model_step();
      logic [7:0] act, cf, both_val, qn;
      int         cmax;
      if (reset) begin
         model_reset();
         return;
      end
      act = enb ? ch_en : 8'h00;
      cf  = act & s & r;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0:       both_val = 8'hFF;
            1:       both_val = 8'h00;
            2:       both_val = m_q[k];
            default: both_val = ~m_q[k];
         endcase
         qn = (m_q[k] & ~act)
            | (act & ((s & ~r) | (~s & ~r & m_q[k]) | (s & r & both_val)));
         m_rise[k] = ~m_q[k] & qn;
         m_fall[k] = m_q[k] & ~qn;
         m_q[k]    = qn;
         m_conf[k] = (conflict_clr ? 8'h00 : m_conf[k]) | cf;
         cmax = (1 << cnt_width(k)) - 1;
         if (conflict_clr)
            m_cnt[k] = (cf != 0) ? 1 : 0;
         else if ((cf != 0) && (m_cnt[k] < cmax))
            m_cnt[k] = m_cnt[k] + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   function automatic logic [47:0] obs(input int k);
      return {q_o[k], qbar_o[k], rise_o[k], fall_o[k], conf_o[k], cnt_o[k]};
   endfunction

   function automatic logic [47:0] expv(input int k);
      return {m_q[k], ~m_q[k], m_rise[k], m_fall[k], m_conf[k], 8'(m_cnt[k])};
   endfunction

   task automatic drive(input logic e, input logic [7:0] ce, input logic [7:0] sv,
                        input logic [7:0] rv, input logic clr);
      enb = e; ch_en = ce; s = sv; r = rv; conflict_clr = clr;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs(k) !== expv(k)) begin
            n_fail++;
            $display("FAIL reset inst%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
      n_checks++;
      if (q_o[0] !== 8'hA5 || qbar_o[0] !== 8'h5A) begin
         n_fail++;
         $display("FAIL reset_const got q=%h qbar=%h exp q=a5 qbar=5a", q_o[0], qbar_o[0]);
      end
      reset = 1'b0;
   endtask

   task automatic test_set_reset();
      drive(1'b1, 8'hFF, 8'h0F, 8'hF0, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs(k) !== expv(k)) begin
            n_fail++;
            $display("FAIL set_reset inst%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
      n_checks++;
      if ({q_o[0], rise_o[0], fall_o[0]} !== {8'h0F, 8'h0A, 8'hA0}) begin
         n_fail++;
         $display("FAIL set_reset_const got q=%h rise=%h fall=%h exp 0f 0a a0",
                  q_o[0], rise_o[0], fall_o[0]);
      end
   endtask

   task automatic test_modes();
      logic [3:0] exp_q0;
      drive(1'b1, 8'hFF, 8'h00, 8'h01, 1'b1);
      tick();
      drive(1'b1, 8'hFF, 8'h01, 8'h01, 1'b0);
      for (int c = 0; c < 4; c++) begin
         tick();
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL modes c%0d inst%0d got %h exp %h", c, k, obs(k), expv(k));
            end
         end
         if (c == 0) begin
            exp_q0 = 4'b1001;  // per-instance q[0] after first conflict: mode0..3
            for (int k = 0; k < 4; k++) begin
               n_checks++;
               if (q_o[k][0] !== exp_q0[k] || conf_o[k][0] !== 1'b1 || cnt_o[k] !== 8'd1) begin
                  n_fail++;
                  $display("FAIL modes_first inst%0d got q0=%b conf0=%b cnt=%0d exp q0=%b 1 1",
                           k, q_o[k][0], conf_o[k][0], cnt_o[k], exp_q0[k]);
               end
            end
         end
      end
   endtask

   task automatic test_enables();
      drive(1'b0, 8'hFF, 8'hFF, 8'h00, 1'b1);
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs(k) !== expv(k)) begin
            n_fail++;
            $display("FAIL enb_off inst%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
      drive(1'b1, 8'h10, 8'hFF, 8'hFF, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs(k) !== expv(k)) begin
            n_fail++;
            $display("FAIL ch_en inst%0d got %h exp %h", k, obs(k), expv(k));
         end
         n_checks++;
         if (conf_o[k] !== 8'h10 || cnt_o[k] !== 8'd1) begin
            n_fail++;
            $display("FAIL ch_en_const inst%0d got conf=%h cnt=%0d exp 10 1", k, conf_o[k], cnt_o[k]);
         end
      end
   endtask

   task automatic test_saturation();
      int exp_cnt[6] = '{1, 2, 3, 3, 3, 3};
      drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
      tick();
      drive(1'b1, 8'h01, 8'h01, 8'h01, 1'b0);
      for (int c = 0; c < 6; c++) begin
         tick();
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL sat c%0d inst%0d got %h exp %h", c, k, obs(k), expv(k));
            end
         end
         n_checks++;
         if (cnt_o[0] !== 8'(exp_cnt[c])) begin
            n_fail++;
            $display("FAIL sat_cnt c%0d got %0d exp %0d", c, cnt_o[0], exp_cnt[c]);
         end
      end
      drive(1'b1, 8'h01, 8'h01, 8'h01, 1'b1);
      tick();
      n_checks++;
      if (cnt_o[0] !== 8'd1 || conf_o[0] !== 8'h01) begin
         n_fail++;
         $display("FAIL clr_with_cf got cnt=%0d conf=%h exp 1 01", cnt_o[0], conf_o[0]);
      end
      drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs(k) !== expv(k) || cnt_o[k] !== 8'd0 || conf_o[k] !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_alone inst%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
      conflict_clr = 1'b0;
   endtask

   task automatic test_async_reset();
      drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      for (int c = 0; c < 3; c++) tick();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs(k) !== expv(k)) begin
            n_fail++;
            $display("FAIL async_reset inst%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
      tick();
      reset = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs(k) !== expv(k)) begin
            n_fail++;
            $display("FAIL after_reset inst%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
      n_checks++;
      if (q_o[3] !== 8'h5A || rise_o[3] !== 8'h5A || fall_o[3] !== 8'hA5) begin
         n_fail++;
         $display("FAIL resume_toggle got q=%h rise=%h fall=%h exp 5a 5a a5",
                  q_o[3], rise_o[3], fall_o[3]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 200; c++) begin
         drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 15) == 0);
         tick();
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL random c%0d inst%0d got %h exp %h", c, k, obs(k), expv(k));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_set_reset();
      test_modes();
      test_enables();
      test_saturation();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
